// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data-memory port between two masters with round-robin grant,
// alignment/range checking and a registered one-cycle response. Lock feature: DM_ARB_LOCK_EN.
module dm_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int LOCK_MAX  = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [1:0]  ReqValid,
    input  logic [1:0]  ReqWr,
    input  logic [5:0]  ReqCtrl,
    input  logic [63:0] ReqAddr,
    input  logic [63:0] ReqWData,
`ifdef DM_ARB_LOCK_EN
    input  logic [1:0]  ReqLock,
    output logic        LockTimeout,
`endif
    output logic [1:0]  Gnt,
    output logic [1:0]  RspValid,
    output logic        RspErr,
    output logic [31:0] RspData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [2:0]  MemCtrl,
    output logic        MemWr,
    input  logic [31:0] MemRData
);
    logic        last_q, last_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  eligible;
    logic        sel, any_gnt, sel_wr, ok, legal, rr_en;
    logic [2:0]  sel_ctrl, size;
    logic [31:0] sel_addr, sel_wdata;
    logic [32:0] last_byte;
    logic        ctrl_ok, align_ok;

`ifdef DM_ARB_LOCK_EN
    // state    | meaning
    // UNLOCKED | plain round-robin between both ports
    // LOCKED0  | only port 0 may be granted, pointer frozen, idle timer running
    // LOCKED1  | only port 1 may be granted, pointer frozen, idle timer running
    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_e;
    localparam int CW = $clog2(LOCK_MAX + 1);
    lock_state_e   lock_state_q, lock_state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_to_q, lock_to_d;
    logic          sel_lock;
`endif

    always_comb begin
        eligible = ReqValid & {2{Rst_n}};
`ifdef DM_ARB_LOCK_EN
        if (lock_state_q == LOCKED0) eligible[1] = 1'b0;
        if (lock_state_q == LOCKED1) eligible[0] = 1'b0;
`endif
        case (eligible)
            2'b11:   Gnt = last_q ? 2'b01 : 2'b10;
            default: Gnt = eligible;
        endcase
    end

    assign any_gnt   = |Gnt;
    assign sel       = Gnt[1];
    assign sel_wr    = sel ? ReqWr[1]         : ReqWr[0];
    assign sel_ctrl  = sel ? ReqCtrl[5:3]     : ReqCtrl[2:0];
    assign sel_addr  = sel ? ReqAddr[63:32]   : ReqAddr[31:0];
    assign sel_wdata = sel ? ReqWData[63:32]  : ReqWData[31:0];

    // Signed/unsigned variants share a size; unsigned variants are read-only.
    always_comb begin
        size     = 3'd0;
        ctrl_ok  = 1'b0;
        align_ok = 1'b0;
        case (sel_ctrl)
            3'b000, 3'b100: begin
                size     = 3'd1;
                align_ok = 1'b1;
                ctrl_ok  = !(sel_wr && sel_ctrl[2]);
            end
            3'b001, 3'b101: begin
                size     = 3'd2;
                align_ok = !sel_addr[0];
                ctrl_ok  = !(sel_wr && sel_ctrl[2]);
            end
            3'b010: begin
                size     = 3'd4;
                align_ok = (sel_addr[1:0] == 2'b00);
                ctrl_ok  = 1'b1;
            end
            default: ;
        endcase
        last_byte = {1'b0, sel_addr} + {30'd0, size} - 33'd1;
        ok        = ctrl_ok && align_ok && (last_byte < 33'(MEM_BYTES));
        legal     = any_gnt && ok;
    end

    always_comb begin
        MemAddr     = legal ? sel_addr  : 32'd0;
        MemWData    = legal ? sel_wdata : 32'd0;
        MemCtrl     = legal ? sel_ctrl  : 3'b000;
        MemWr       = legal && sel_wr && Rst_n;
        rsp_valid_d = Gnt;
        rsp_err_d   = any_gnt && !ok;
        rsp_data_d  = (legal && !sel_wr) ? MemRData : 32'd0;
        rr_en       = 1'b1;
`ifdef DM_ARB_LOCK_EN
        rr_en = (lock_state_q == UNLOCKED);
`endif
        last_d = (any_gnt && rr_en) ? sel : last_q;
    end

`ifdef DM_ARB_LOCK_EN
    assign sel_lock = sel ? ReqLock[1] : ReqLock[0];

    always_comb begin
        lock_state_d = lock_state_q;
        lock_cnt_d   = lock_cnt_q;
        lock_to_d    = 1'b0;
        case (lock_state_q)
            UNLOCKED: begin
                if (any_gnt && sel_lock) begin
                    lock_state_d = sel ? LOCKED1 : LOCKED0;
                    lock_cnt_d   = CW'(LOCK_MAX - 1);
                end
            end
            default: begin
                // any grant here is necessarily to the lock owner
                if (any_gnt) begin
                    lock_cnt_d = CW'(LOCK_MAX - 1);
                    if (!sel_lock) lock_state_d = UNLOCKED;
                end else if (lock_cnt_q == '0) begin
                    lock_state_d = UNLOCKED;
                    lock_to_d    = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q - CW'(1);
                end
            end
        endcase
    end

    assign LockTimeout = lock_to_q;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
`ifdef DM_ARB_LOCK_EN
            lock_state_q <= UNLOCKED;
            lock_cnt_q   <= '0;
            lock_to_q    <= 1'b0;
`endif
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
`ifdef DM_ARB_LOCK_EN
            lock_state_q <= lock_state_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_to_q    <= lock_to_d;
`endif
        end
    end

    assign RspValid = rsp_valid_q;
    assign RspErr   = rsp_err_q;
    assign RspData  = rsp_data_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: byte-array memory environment, directed scenarios and random
// traffic checked against a request-level reference model.
module tb_dm_arbiter;
    localparam int MEM_BYTES = 1024;
    localparam int LOCK_MAX  = 16;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [1:0]  ReqValid, ReqWr, Gnt, RspValid;
    logic [5:0]  ReqCtrl;
    logic [63:0] ReqAddr, ReqWData;
    logic        RspErr, MemWr;
    logic [31:0] RspData, MemAddr, MemWData, MemRData;
    logic [2:0]  MemCtrl;
`ifdef DM_ARB_LOCK_EN
    logic [1:0]  ReqLock;
    logic        LockTimeout;
`endif

    dm_arbiter #(.MEM_BYTES(MEM_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(ReqValid), .ReqWr(ReqWr), .ReqCtrl(ReqCtrl),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData),
`ifdef DM_ARB_LOCK_EN
        .ReqLock(ReqLock), .LockTimeout(LockTimeout),
`endif
        .Gnt(Gnt), .RspValid(RspValid), .RspErr(RspErr), .RspData(RspData),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemCtrl(MemCtrl), .MemWr(MemWr),
        .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    // Memory environment: combinational read with extension, write on rising edge.
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] b0, b1, b2, b3;

    function automatic int ix(input logic [31:0] a);
        return int'(a[15:0]) % MEM_BYTES;
    endfunction

    always_comb begin
        b0 = mem[ix(MemAddr)];
        b1 = mem[ix(MemAddr + 32'd1)];
        b2 = mem[ix(MemAddr + 32'd2)];
        b3 = mem[ix(MemAddr + 32'd3)];
        case (MemCtrl)
            3'b000:  MemRData = {{24{b0[7]}}, b0};
            3'b001:  MemRData = {{16{b1[7]}}, b1, b0};
            3'b010:  MemRData = {b3, b2, b1, b0};
            3'b100:  MemRData = {24'h0, b0};
            3'b101:  MemRData = {16'h0, b1, b0};
            default: MemRData = 32'h0;
        endcase
    end

    always @(posedge Clk) begin
        if (MemWr) begin
            mem[ix(MemAddr)] <= MemWData[7:0];
            if (MemCtrl[1:0] != 2'b00) mem[ix(MemAddr + 32'd1)] <= MemWData[15:8];
            if (MemCtrl[1:0] == 2'b10) begin
                mem[ix(MemAddr + 32'd2)] <= MemWData[23:16];
                mem[ix(MemAddr + 32'd3)] <= MemWData[31:24];
            end
        end
    end

    // Reference model state
    typedef struct {
        logic        v;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } req_t;

    req_t       rq [2];
    logic [7:0] gold [MEM_BYTES];
    int         m_last, m_lock, m_idle;
    int         n_chk = 0, n_err = 0;
    logic [1:0] r_gnt;
    logic       r_err, r_memwr, r_to;
    logic [31:0] r_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_legal(input req_t r);
        int sz = acc_size(r.ctrl);
        if (sz == 0) return 0;
        if (r.wr && r.ctrl[2]) return 0;
        if ((r.addr % 32'(sz)) != 0) return 0;
        if (longint'({32'h0, r.addr}) + longint'(sz) - 1 >= longint'(MEM_BYTES)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] gold_read(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] v = 32'h0;
        int sz = acc_size(c);
        for (int k = 0; k < sz; k++) v[8*k +: 8] = gold[int'(a) + k];
        if (!c[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!c[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < 2; p++) begin
            ReqValid[p]          = rq[p].v;
            ReqWr[p]             = rq[p].wr;
            ReqCtrl[3*p +: 3]    = rq[p].ctrl;
            ReqAddr[32*p +: 32]  = rq[p].addr;
            ReqWData[32*p +: 32] = rq[p].wdata;
`ifdef DM_ARB_LOCK_EN
            ReqLock[p]           = rq[p].lock;
`endif
        end
    endtask

    task automatic set_req(input int p, input logic wr, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] d, input logic lk);
        rq[p].v = 1'b1; rq[p].wr = wr; rq[p].ctrl = c;
        rq[p].addr = a; rq[p].wdata = d; rq[p].lock = lk;
    endtask

    task automatic new_req(input int p);
        int m;
        logic [2:0] c;
        logic [31:0] a;
        m = $urandom_range(0, 9);
        if (m < 8) begin
            case ($urandom_range(0, 4))
                0: c = 3'b000; 1: c = 3'b001; 2: c = 3'b010; 3: c = 3'b100;
                default: c = 3'b101;
            endcase
        end else c = 3'($urandom_range(0, 7));
        m = $urandom_range(0, 9);
        if (m < 7)      a = 32'($urandom_range(0, 63));
        else if (m < 9) a = 32'(MEM_BYTES - 4 + $urandom_range(0, 3));
        else            a = $urandom;
        set_req(p, 1'($urandom_range(0, 1)), c, a, $urandom, ($urandom_range(0, 7) == 0));
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic step();
        int w;
        bit e0, e1, ok, ewr, eto;
        logic [1:0] eg;
        logic [31:0] ed;
        drive_inputs();
        #4;
        e0 = rq[0].v && (m_lock != 1);
        e1 = rq[1].v && (m_lock != 0);
        if (e0 && e1) w = 1 - m_last;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        else          w = -1;
        eg = (w < 0) ? 2'b00 : 2'(1 << w);
        ok  = (w >= 0) && is_legal(rq[w]);
        ewr = ok && rq[w].wr;
        ed  = (ok && !rq[w].wr) ? gold_read(rq[w].addr, rq[w].ctrl) : 32'h0;
        r_gnt = Gnt; r_memwr = MemWr;
        chk("gnt", Gnt, eg);
        chk("memwr", MemWr, ewr);
        if (ok) begin
            chk("memaddr", MemAddr, rq[w].addr);
            chk("memctrl", MemCtrl, rq[w].ctrl);
            if (ewr) chk("memwdata", MemWData, rq[w].wdata);
        end else if (w < 0) begin
            chk("idle_addr", MemAddr, 32'h0);
            chk("idle_ctrl", MemCtrl, 3'b000);
        end
        @(posedge Clk);
        #1;
        r_err = RspErr; r_data = RspData;
        chk("rspvalid", RspValid, eg);
        if (w >= 0) begin
            chk("rsperr", RspErr, !ok);
            chk("rspdata", RspData, ed);
        end
        if (ewr)
            for (int k = 0; k < acc_size(rq[w].ctrl); k++)
                gold[int'(rq[w].addr) + k] = rq[w].wdata[8*k +: 8];
        eto = 0;
        if (m_lock < 0) begin
            if (w >= 0) m_last = w;
            if (w >= 0 && rq[w].lock) begin m_lock = w; m_idle = 0; end
        end else if (w == m_lock) begin
            m_idle = 0;
            if (!rq[w].lock) m_lock = -1;
        end else begin
            m_idle++;
            if (m_idle == LOCK_MAX) begin m_lock = -1; m_idle = 0; eto = 1; end
        end
        r_to = eto;
`ifdef DM_ARB_LOCK_EN
        chk("locktimeout", LockTimeout, eto);
`endif
        if (w >= 0) rq[w].v = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq[0].v || rq[1].v) && n < 40) begin step(); n++; end
        if (rq[0].v || rq[1].v) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    logic [1:0] seq [4];

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin mem[i] = 8'h0; gold[i] = 8'h0; end
        m_last = 1; m_lock = -1; m_idle = 0;
        Rst_n = 1'b0;
        set_req(0, 1'b1, 3'b010, 32'h10, 32'h1111_1111, 1'b0);
        set_req(1, 1'b1, 3'b010, 32'h14, 32'h2222_2222, 1'b0);
        drive_inputs();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_gnt", Gnt, 2'b00);
        chk("rst_memwr", MemWr, 1'b0);
        chk("rst_rspvalid", RspValid, 2'b00);
        chk("rst_rsperr", RspErr, 1'b0);
        chk("rst_rspdata", RspData, 32'h0);
`ifdef DM_ARB_LOCK_EN
        chk("rst_locktimeout", LockTimeout, 1'b0);
`endif
        rq[0].v = 1'b0; rq[1].v = 1'b0;
        Rst_n = 1'b1;

        // Both ports read continuously from reset: strict alternation starting at port 0.
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p].v) set_req(p, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
            step();
            seq[k] = r_gnt;
        end
        chk("rr_0", seq[0], 2'b01);
        chk("rr_1", seq[1], 2'b10);
        chk("rr_2", seq[2], 2'b01);
        chk("rr_3", seq[3], 2'b10);
        drain();

        set_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step();
        chk("wr_gnt", r_gnt, 2'b01);
        chk("wr_err", r_err, 1'b0);
        set_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        step();
        chk("rd_word", r_data, 32'hDEAD_BEEF);

        set_req(1, 1'b1, 3'b010, 32'h13, 32'h1234_5678, 1'b0);
        step();
        chk("mis_gnt", r_gnt, 2'b10);
        chk("mis_memwr", r_memwr, 1'b0);
        chk("mis_err", r_err, 1'b1);
        chk("mis_data", r_data, 32'h0);
        set_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        step();
        chk("rd_after_mis", r_data, 32'hDEAD_BEEF);

        set_req(0, 1'b0, 3'b001, 32'(MEM_BYTES - 1), 32'h0, 1'b0);
        step();
        chk("oor_half_err", r_err, 1'b1);
        set_req(1, 1'b0, 3'b010, 32'(MEM_BYTES), 32'h0, 1'b0);
        step();
        chk("oor_word_err", r_err, 1'b1);
        set_req(0, 1'b0, 3'b010, 32'(MEM_BYTES - 4), 32'h0, 1'b0);
        step();
        chk("top_word_err", r_err, 1'b0);
        set_req(0, 1'b1, 3'b000, 32'h20, 32'h0000_0080, 1'b0);
        step();
        set_req(0, 1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
        step();
        chk("rd_sbyte", r_data, 32'hFFFF_FF80);
        set_req(1, 1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
        step();
        chk("rd_ubyte", r_data, 32'h0000_0080);

`ifdef DM_ARB_LOCK_EN
        set_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        step();
        set_req(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        step();
        chk("lock_blocks", r_gnt, 2'b00);
        set_req(0, 1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 1'b0);
        step();
        chk("unlock_gnt", r_gnt, 2'b01);
        step();
        chk("after_unlock", r_gnt, 2'b10);
        set_req(0, 1'b0, 3'b010, 32'h24, 32'h0, 1'b1);
        step();
        set_req(1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b0);
        for (int k = 0; k < LOCK_MAX; k++) begin
            step();
            if (k == LOCK_MAX - 2) chk("to_not_early", r_to, 1'b0);
        end
        chk("to_pulse", LockTimeout, 1'b1);
        step();
        chk("to_gnt1", r_gnt, 2'b10);
`endif

        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p].v && $urandom_range(0, 99) < 60) new_req(p);
`ifndef DM_ARB_LOCK_EN
            rq[0].lock = 1'b0; rq[1].lock = 1'b0;
`endif
            step();
        end

        // Reset asserted in the middle of a grant cycle.
        for (int p = 0; p < 2; p++)
            if (!rq[p].v) set_req(p, 1'b1, 3'b010, 32'h30, 32'h5555_AAAA, 1'b0);
        rq[0].lock = 1'b0; rq[1].lock = 1'b0;
        drive_inputs();
        #4;
        chk("pre_rst_gnt", {31'h0, |Gnt}, 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("midrst_gnt", Gnt, 2'b00);
        chk("midrst_memwr", MemWr, 1'b0);
        @(posedge Clk);
        #1;
        chk("midrst_rspvalid", RspValid, 2'b00);
        Rst_n = 1'b1;
        m_last = 1; m_lock = -1; m_idle = 0;
        step();
        chk("post_rst_first", r_gnt, 2'b01);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
